scale_ctrl: RTL

SCALE_CTRL -- requirements
Module: scale_ctrl

---
 rtl/scale_ctrl_pkg.sv | 22 ++
 rtl/scale_ctrl_if.sv | 31 +++
 rtl/scale_addr_gen.sv | 63 ++++++
 rtl/scale_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/scale_ctrl_pkg.sv
// Shared types for the image scaling controller: FSM states and mode encodings.
package scale_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [1:0] MODE_COPY = 2'b00;
    localparam logic [1:0] MODE_ZIN  = 2'b01;
    localparam logic [1:0] MODE_ZOUT = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    // A pass is in flight in every state that belongs to the pixel pipeline.
    function automatic logic is_busy(input state_e s);
        return (s == READ) || (s == WAIT) || (s == WRITE);
    endfunction

endpackage

// File: rtl/scale_ctrl_if.sv
// Command, source-read and destination-write signals of the scaling controller.
interface scale_ctrl_if #(
    parameter int SRC_W = 4,
    parameter int SRC_H = 4,
    parameter int PIX_W = 8
);
    localparam int SA_W = $clog2(SRC_W * SRC_H);
    localparam int DA_W = $clog2(4 * SRC_W * SRC_H);

    logic             start;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic             err;
    logic             src_rd_en;
    logic [SA_W-1:0]  src_addr;
    logic [PIX_W-1:0] src_data;
    logic             dst_we;
    logic [DA_W-1:0]  dst_addr;
    logic [PIX_W-1:0] dst_data;

    modport master (
        output start, mode, src_data,
        input  busy, done, err, src_rd_en, src_addr, dst_we, dst_addr, dst_data
    );

    modport slave (
        input  start, mode, src_data,
        output busy, done, err, src_rd_en, src_addr, dst_we, dst_addr, dst_data
    );
endinterface

// File: rtl/scale_addr_gen.sv
// Maps an output pixel (r,c) to its source and destination addresses for a mode,
// and reports the output dimensions of that mode.
module scale_addr_gen
    import scale_ctrl_pkg::*;
#(
    parameter int SRC_W = 4,
    parameter int SRC_H = 4,
    parameter int SA_W  = $clog2(SRC_W * SRC_H),
    parameter int DA_W  = $clog2(4 * SRC_W * SRC_H),
    parameter int R_W   = $clog2(2 * SRC_H),
    parameter int C_W   = $clog2(2 * SRC_W)
) (
    input  logic [1:0]      mode_i,
    input  logic [R_W-1:0]  r_i,
    input  logic [C_W-1:0]  c_i,
    output logic [SA_W-1:0] src_addr_o,
    output logic [DA_W-1:0] dst_addr_o,
    output logic [C_W:0]    out_w_o,
    output logic [R_W:0]    out_h_o
);

    logic [SA_W-1:0] r_s;
    logic [SA_W-1:0] c_s;
    logic [SA_W-1:0] src_w_s;
    logic [DA_W-1:0] r_d_s;
    logic [DA_W-1:0] c_d_s;
    logic [DA_W-1:0] out_w_d_s;

    // Every intermediate is at least as wide as its final result, so the
    // modular products below equal the true addresses.
    always_comb begin
        r_s     = SA_W'(r_i);
        c_s     = SA_W'(c_i);
        src_w_s = SA_W'(SRC_W);
        case (mode_i)
            MODE_ZIN: begin
                out_w_o    = (C_W + 1)'(2 * SRC_W);
                out_h_o    = (R_W + 1)'(2 * SRC_H);
                src_addr_o = (r_s >> 1) * src_w_s + (c_s >> 1);
            end
            MODE_ZOUT: begin
                out_w_o    = (C_W + 1)'(SRC_W / 2);
                out_h_o    = (R_W + 1)'(SRC_H / 2);
                src_addr_o = (r_s << 1) * src_w_s + (c_s << 1);
            end
            MODE_COPY: begin
                out_w_o    = (C_W + 1)'(SRC_W);
                out_h_o    = (R_W + 1)'(SRC_H);
                src_addr_o = r_s * src_w_s + c_s;
            end
            default: begin
                out_w_o    = (C_W + 1)'(SRC_W);
                out_h_o    = (R_W + 1)'(SRC_H);
                src_addr_o = r_s * src_w_s + c_s;
            end
        endcase
        r_d_s      = DA_W'(r_i);
        c_d_s      = DA_W'(c_i);
        out_w_d_s  = DA_W'(out_w_o);
        dst_addr_o = r_d_s * out_w_d_s + c_d_s;
    end

endmodule

// File: rtl/scale_ctrl.sv
// Image scaling controller: walks the output raster one pixel per
// READ->WAIT->WRITE triplet, copying, doubling or halving a source image.
module scale_ctrl
    import scale_ctrl_pkg::*;
#(
    parameter int SRC_W = 4,
    parameter int SRC_H = 4,
    parameter int PIX_W = 8
) (
    input  logic         clock,
    input  logic         reset,
    scale_ctrl_if.slave  bus
);

    localparam int SA_W = $clog2(SRC_W * SRC_H);
    localparam int DA_W = $clog2(4 * SRC_W * SRC_H);
    localparam int R_W  = $clog2(2 * SRC_H);
    localparam int C_W  = $clog2(2 * SRC_W);

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [R_W-1:0]   r_q, r_d;
    logic [C_W-1:0]   c_q, c_d;
    logic [PIX_W-1:0] pix_q, pix_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rd_en_q, rd_en_d;
    logic [SA_W-1:0]  src_addr_q, src_addr_d;
    logic             we_q, we_d;
    logic [DA_W-1:0]  dst_addr_q, dst_addr_d;
    logic [PIX_W-1:0] dst_data_q, dst_data_d;

    logic [SA_W-1:0]  gen_src_s;
    logic [DA_W-1:0]  gen_dst_s;
    logic [C_W:0]     out_w_s;
    logic [R_W:0]     out_h_s;
    logic             last_col_s;
    logic             last_row_s;

    // Latched mode drives the generator: pixel (0,0) maps to address 0 in every
    // mode, so the first READ does not need the freshly sampled mode.
    scale_addr_gen #(
        .SRC_W (SRC_W),
        .SRC_H (SRC_H),
        .SA_W  (SA_W),
        .DA_W  (DA_W),
        .R_W   (R_W),
        .C_W   (C_W)
    ) u_addr_gen (
        .mode_i     (mode_q),
        .r_i        (r_d),
        .c_i        (c_d),
        .src_addr_o (gen_src_s),
        .dst_addr_o (gen_dst_s),
        .out_w_o    (out_w_s),
        .out_h_o    (out_h_s)
    );

    assign last_col_s = ((C_W + 1)'(c_q) == (out_w_s - (C_W + 1)'(1'b1)));
    assign last_row_s = ((R_W + 1)'(r_q) == (out_h_s - (R_W + 1)'(1'b1)));

    // Next-state, raster counters, mode latch and pixel capture.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        r_d     = r_q;
        c_d     = c_q;
        pix_d   = pix_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.mode == MODE_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = bus.mode;
                        r_d     = {R_W{1'b0}};
                        c_d     = {C_W{1'b0}};
                        state_d = READ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                pix_d   = bus.src_data;
                state_d = WRITE;
            end
            WRITE: begin
                if (last_col_s) begin
                    c_d = {C_W{1'b0}};
                    if (last_row_s) begin
                        r_d     = {R_W{1'b0}};
                        state_d = DONE;
                    end else begin
                        r_d     = r_q + R_W'(1'b1);
                        state_d = READ;
                    end
                end else begin
                    c_d     = c_q + C_W'(1'b1);
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the state being entered.
    always_comb begin
        rd_en_d = (state_d == READ);
        we_d    = (state_d == WRITE);
        busy_d  = is_busy(state_d);
        done_d  = (state_d == DONE);
        if (rd_en_d) begin
            src_addr_d = gen_src_s;
        end else begin
            src_addr_d = {SA_W{1'b0}};
        end
        if (we_d) begin
            dst_addr_d = gen_dst_s;
            dst_data_d = pix_d;
        end else begin
            dst_addr_d = {DA_W{1'b0}};
            dst_data_d = {PIX_W{1'b0}};
        end
    end

    // State, counters and registered outputs; reset aborts any pass at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mode_q     <= MODE_COPY;
            r_q        <= {R_W{1'b0}};
            c_q        <= {C_W{1'b0}};
            pix_q      <= {PIX_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            src_addr_q <= {SA_W{1'b0}};
            we_q       <= 1'b0;
            dst_addr_q <= {DA_W{1'b0}};
            dst_data_q <= {PIX_W{1'b0}};
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            r_q        <= r_d;
            c_q        <= c_d;
            pix_q      <= pix_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_en_q    <= rd_en_d;
            src_addr_q <= src_addr_d;
            we_q       <= we_d;
            dst_addr_q <= dst_addr_d;
            dst_data_q <= dst_data_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.src_rd_en = rd_en_q;
    assign bus.src_addr  = src_addr_q;
    assign bus.dst_we    = we_q;
    assign bus.dst_addr  = dst_addr_q;
    assign bus.dst_data  = dst_data_q;

endmodule
